irq_ctrl: RTL and testbench

- Programmable interrupt controller between the peripheral IRQ lines (timer, MiniUART, dip switch, user key, spares) and the CPU HWInt input.
- Latches, masks and prioritises up to six sources. Drives one registered interrupt request to the CPU.
- Runs a claim/complete (EOI) handshake so the handler learns which source fired and new requests are held off until service ends.
- Sits on the bridge as one more memory-mapped device.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_ctrl.sv | 108 ++++++++++
 tb/tb_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register word indices,
// FSM state encoding and CLAIM register layout.
package irq_pkg;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_MODE  = 2'd2;
    localparam logic [1:0] REG_CLAIM = 2'd3;

    localparam int unsigned CLAIM_VALID_BIT = 31;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CLAIMED = 1'b1
    } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt set.
module irq_prio_enc #(
    parameter int unsigned N_SRC = 6
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [2:0]       id
);

    always_comb begin
        any = |req;
        id  = '0;
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises sources
// and runs a claim/EOI handshake towards the CPU interrupt input.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC    = 6,
    parameter logic [5:0]  MODE_RST = 6'b000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ADD_I,
    input  logic [31:0]      DAT_I,
    input  logic             WE_I,
    input  logic             STB_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] src_i,
    output logic             irq_o,
    output logic [2:0]       claim_id_o
);

    logic [N_SRC-1:0] mask_q, mode_q, pend_q, src_prev;
    logic [N_SRC-1:0] pending, act, rise, clr, pend_d;
    state_e           state;
    logic [2:0]       claim_id, win_id;
    logic             irq, any, rd, wr, claim, eoi;
    logic [1:0]       word;

    assign word = ADD_I[3:2];
    assign rd   = STB_I & ~WE_I;
    assign wr   = STB_I & WE_I;

    // Edge sources come from the latch, level sources follow the wire live.
    assign pending = (pend_q & mode_q) | (src_i & ~mode_q);
    assign act     = pending & mask_q;
    assign rise    = src_i & ~src_prev & mode_q;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req (act),
        .any (any),
        .id  (win_id)
    );

    assign claim = rd && (word == REG_CLAIM) && (state == ST_IDLE) && any;
    assign eoi   = wr && (word == REG_CLAIM) && (state == ST_CLAIMED);

    always_comb begin
        clr = '0;
        if (wr && (word == REG_PEND)) clr = DAT_I[N_SRC-1:0];
        if (claim) clr[win_id] = 1'b1;
        // A new edge in the same cycle as a clear keeps the bit set.
        pend_d = ((pend_q & ~clr) | rise) & mode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            mode_q   <= MODE_RST[N_SRC-1:0];
            pend_q   <= '0;
            src_prev <= '0;
            state    <= ST_IDLE;
            claim_id <= '0;
            irq      <= 1'b0;
        end else begin
            src_prev <= src_i;
            pend_q   <= pend_d;
            if (wr && (word == REG_MASK)) mask_q <= DAT_I[N_SRC-1:0];
            if (wr && (word == REG_MODE)) mode_q <= DAT_I[N_SRC-1:0];
            case (state)
                ST_IDLE: begin
                    irq <= any & ~claim;
                    if (claim) begin
                        claim_id <= win_id;
                        state    <= ST_CLAIMED;
                    end
                end
                ST_CLAIMED: begin
                    irq <= 1'b0;
                    if (eoi) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        DAT_O = '0;
        case (word)
            REG_MASK: DAT_O[N_SRC-1:0] = mask_q;
            REG_PEND: DAT_O[N_SRC-1:0] = pending;
            REG_MODE: DAT_O[N_SRC-1:0] = mode_q;
            default: begin
                if (state == ST_CLAIMED) begin
                    DAT_O[CLAIM_VALID_BIT] = 1'b1;
                    DAT_O[2:0]             = claim_id;
                end else if (any) begin
                    DAT_O[CLAIM_VALID_BIT] = 1'b1;
                    DAT_O[2:0]             = win_id;
                end
            end
        endcase
    end

    assign irq_o      = irq;
    assign claim_id_o = claim_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed plus randomized bench for irq_ctrl against a cycle-level
// behavioural model of the interrupt controller rules.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  add = '0;
    logic [31:0] dat = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] dout;
    logic [5:0]  src = '0;
    logic        irq;
    logic [2:0]  cid;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctrl #(
        .N_SRC    (6),
        .MODE_RST (6'b000000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ADD_I      (add),
        .DAT_I      (dat),
        .WE_I       (we),
        .STB_I      (stb),
        .DAT_O      (dout),
        .src_i      (src),
        .irq_o      (irq),
        .claim_id_o (cid)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [5:0] m_mask, m_mode, m_pend, m_prev;
    bit       m_busy, m_irq;
    int       m_id;

    function automatic bit [5:0] m_pending();
        bit [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = m_mode[i] ? m_pend[i] : src[i];
        return p;
    endfunction

    function automatic int m_win();
        bit [5:0] a;
        a = m_pending() & m_mask;
        for (int i = 0; i < 6; i++) if (a[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_read(int w);
        int win;
        win = m_win();
        case (w)
            0: return {26'b0, m_mask};
            1: return {26'b0, m_pending()};
            2: return {26'b0, m_mode};
            default: begin
                if (m_busy) return 32'h8000_0000 | 32'(m_id);
                if (win >= 0) return 32'h8000_0000 | 32'(win);
                return 32'h0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the pre-edge inputs, advance, then check outputs.
    task automatic cyc();
        bit       rd, wr, claim, eoi, clr, rise, n_irq;
        bit [5:0] n_pend;
        int       w, win;
        rd    = stb && !we;
        wr    = stb && we;
        w     = int'(add[3:2]);
        win   = m_win();
        claim = rd && (w == 3) && !m_busy && (win >= 0);
        eoi   = wr && (w == 3) && m_busy;
        for (int i = 0; i < 6; i++) begin
            clr       = (wr && (w == 1) && dat[i]) || (claim && (win == i));
            rise      = src[i] && !m_prev[i];
            n_pend[i] = m_mode[i] && (rise || (m_pend[i] && !clr));
        end
        n_irq = !m_busy && !claim && (win >= 0);
        @(posedge clk);
        if (reset) begin
            m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
            m_busy = 1'b0; m_irq = 1'b0; m_id = 0;
        end else begin
            if (wr && (w == 0)) m_mask = dat[5:0];
            if (wr && (w == 2)) m_mode = dat[5:0];
            m_pend = n_pend;
            m_prev = src;
            m_irq  = n_irq;
            if (claim) begin
                m_busy = 1'b1;
                m_id   = win;
            end else if (eoi) begin
                m_busy = 1'b0;
            end
        end
        #1;
        chk("irq_o", {31'b0, irq}, {31'b0, m_irq});
        chk("claim_id_o", {29'b0, cid}, 32'(m_id));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr_reg(input int w, input logic [31:0] d);
        add = 4'(w << 2); dat = d; we = 1'b1; stb = 1'b1;
        cyc();
        we = 1'b0; stb = 1'b0; dat = '0;
    endtask

    task automatic rd_reg(input int w, output logic [31:0] v);
        add = 4'(w << 2); we = 1'b0; stb = 1'b1;
        #1;
        v = dout;
        chk($sformatf("read_w%0d", w), v, m_read(w));
        cyc();
        stb = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    logic [31:0] v;
    int          op;

    initial begin
        do_reset();

        // 1: single edge source, latency, claim, EOI
        wr_reg(0, 32'h3F);
        wr_reg(2, 32'h3F);
        src = 6'h04;
        cyc();
        chk("t1_irq_k", {31'b0, irq}, 32'h0);
        src = 6'h00;
        cyc();
        chk("t1_irq_k1", {31'b0, irq}, 32'h1);
        rd_reg(1, v); chk("t1_pend", v, 32'h04);
        rd_reg(3, v); chk("t1_claim", v, 32'h8000_0002);
        chk("t1_irq_drop", {31'b0, irq}, 32'h0);
        rd_reg(1, v); chk("t1_pend_clr", v, 32'h0);
        idle(3);
        wr_reg(3, 32'h0);
        idle(2);
        chk("t1_irq_after_eoi", {31'b0, irq}, 32'h0);

        // 2: two simultaneous edges served in priority order
        src = 6'h28;
        cyc();
        src = 6'h00;
        cyc();
        rd_reg(3, v); chk("t2_claim1", v, 32'h8000_0003);
        wr_reg(3, 32'h0);
        cyc();
        chk("t2_reassert", {31'b0, irq}, 32'h1);
        rd_reg(3, v); chk("t2_claim2", v, 32'h8000_0005);
        wr_reg(3, 32'h0);

        // 3: level source held high
        wr_reg(2, 32'h00);
        wr_reg(0, 32'h01);
        src = 6'h01;
        idle(2);
        rd_reg(3, v); chk("t3_claim", v, 32'h8000_0000);
        wr_reg(3, 32'h0);
        cyc();
        chk("t3_level_reassert", {31'b0, irq}, 32'h1);
        src = 6'h00;
        idle(2);
        rd_reg(1, v); chk("t3_pend", v, 32'h0);
        chk("t3_irq", {31'b0, irq}, 32'h0);

        // 4: masked source latches, unmask fires, software clear suppresses
        wr_reg(2, 32'h3F);
        wr_reg(0, 32'h00);
        src = 6'h10; cyc(); src = 6'h00; idle(2);
        rd_reg(1, v); chk("t4_pend", v, 32'h10);
        chk("t4_masked_irq", {31'b0, irq}, 32'h0);
        wr_reg(0, 32'h10);
        cyc();
        chk("t4_unmask_irq", {31'b0, irq}, 32'h1);
        rd_reg(3, v); chk("t4_claim", v, 32'h8000_0004);
        wr_reg(3, 32'h0);
        wr_reg(0, 32'h00);
        src = 6'h10; cyc(); src = 6'h00; cyc();
        wr_reg(1, 32'h10);
        rd_reg(1, v); chk("t4_sw_clear", v, 32'h0);
        wr_reg(0, 32'h10);
        idle(2);
        chk("t4_no_irq", {31'b0, irq}, 32'h0);

        // 5: empty claim, idle EOI, edge racing the claim of the same source
        rd_reg(3, v); chk("t5_empty_claim", v, 32'h0);
        wr_reg(3, 32'h0);
        rd_reg(3, v); chk("t5_still_idle", v, 32'h0);
        wr_reg(0, 32'h3F);
        src = 6'h02; cyc(); src = 6'h00; idle(2);
        src = 6'h02;
        rd_reg(3, v); chk("t5_claim", v, 32'h8000_0001);
        src = 6'h00;
        rd_reg(1, v); chk("t5_pend_kept", v, 32'h02);
        wr_reg(3, 32'h0);
        rd_reg(3, v); chk("t5_reclaim", v, 32'h8000_0001);
        wr_reg(3, 32'h0);

        // 6: reset while a claim is outstanding with edges pending
        src = 6'h06; cyc(); src = 6'h00; idle(2);
        rd_reg(3, v);
        src = 6'h08; cyc(); src = 6'h00;
        do_reset();
        chk("t6_irq", {31'b0, irq}, 32'h0);
        chk("t6_cid", {29'b0, cid}, 32'h0);
        rd_reg(0, v); chk("t6_mask", v, 32'h0);
        rd_reg(1, v); chk("t6_pend", v, 32'h0);
        rd_reg(2, v); chk("t6_mode", v, 32'h0);
        rd_reg(3, v); chk("t6_claim", v, 32'h0);

        // Randomized traffic against the model
        wr_reg(2, 32'($urandom_range(0, 63)));
        wr_reg(0, 32'($urandom_range(0, 63)));
        for (int n = 0; n < 600; n++) begin
            src = src ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            op  = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: rd_reg(int'($urandom_range(0, 3)), v);
                3: wr_reg(0, 32'($urandom));
                4: wr_reg(1, 32'($urandom));
                5, 6: wr_reg(3, 32'($urandom));
                default: cyc();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
